// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 digest disassembler:
//   - sha256_digest_width_lp : width of one digest word (256 bits)
//   - sha256_state_e         : disassembler states (IDLE_S / SEND_S)
//   - beat_cnt_width_f       : beat counter width for N beats, never below 1
// ---------------------------------------------------------------------------
package sha256_pkg;

   localparam int unsigned sha256_digest_width_lp = 256;

   typedef enum logic [0:0] {
      IDLE_S = 1'b0,
      SEND_S = 1'b1
   } sha256_state_e;

   // A single-beat ring still needs a 1-bit counter so the port stays legal.
   function automatic int unsigned beat_cnt_width_f(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sha256_beat_counter.sv
// ---------------------------------------------------------------------------
// sha256_beat_counter
// Index of the ring beat currently being presented.
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous active-high reset (counter -> 0)
//   en_i     : block enable; low freezes the counter
//   clr_i    : restart at beat 0 (new digest captured)
//   inc_i    : advance to next beat (current beat consumed)
//   cnt_o    : current beat index
//   last_o   : current beat is the final beat (n_p-1)
// ---------------------------------------------------------------------------
module sha256_beat_counter
   import sha256_pkg::*;
#(
   parameter int unsigned n_p     = 8,
   parameter int unsigned cnt_w_p = 3
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic               inc_i,
   output logic [cnt_w_p-1:0] cnt_o,
   output logic               last_o
);

   logic [cnt_w_p-1:0] cnt_q;
   logic [cnt_w_p-1:0] cnt_d;

   assign last_o = (cnt_q == cnt_w_p'(n_p - 1));
   assign cnt_o  = cnt_q;

   // Next count: clear wins; the final beat never wraps, a new digest clears it.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i && clr_i) begin
         cnt_d = '0;
      end else if (en_i && inc_i && !last_o) begin
         cnt_d = cnt_q + cnt_w_p'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sha256_disassembler.sv
// ---------------------------------------------------------------------------
// sha256_disassembler
// Captures one 256-bit digest and streams it onto a ring as
// N = 256/ring_width_p beats, least-significant beat first.
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous active-high reset
//   en_i     : block enable; low freezes state and hides both handshakes
//   v_i      : digest valid from hashing core
//   data_i   : 256-bit digest
//   ready_o  : block can accept a digest this cycle
//   v_o      : data_o carries a valid ring beat
//   data_o   : current ring beat
//   yumi_i   : downstream consumes the current beat
// id_p is an instance tag only; it does not influence the datapath.
// ---------------------------------------------------------------------------
module sha256_disassembler
   import sha256_pkg::*;
#(
   parameter int unsigned ring_width_p = 32,
   parameter              id_p         = "inv"
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    en_i,
   input  logic                    v_i,
   input  logic [255:0]            data_i,
   output logic                    ready_o,
   output logic                    v_o,
   output logic [ring_width_p-1:0] data_o,
   input  logic                    yumi_i
);

   localparam int unsigned dw_lp    = sha256_digest_width_lp;
   localparam int unsigned n_lp     = dw_lp / ring_width_p;
   localparam int unsigned cnt_w_lp = beat_cnt_width_f(n_lp);

   sha256_state_e state_q;
   sha256_state_e state_d;
   logic [dw_lp-1:0] data_q;
   logic [dw_lp-1:0] data_d;
   logic [n_lp-1:0][ring_width_p-1:0] beats;
   logic [cnt_w_lp-1:0] cnt;
   logic last;
   logic accept;
   logic consume;

   // Handshakes are qualified by reset so nothing fires while it is held.
   assign accept  = en_i & ~reset_i & (state_q == IDLE_S) & v_i;
   // yumi_i is only honoured while a beat is actually being offered.
   assign consume = en_i & ~reset_i & (state_q == SEND_S) & yumi_i;

   sha256_beat_counter #(
      .n_p     (n_lp),
      .cnt_w_p (cnt_w_lp)
   ) u_beat_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (en_i),
      .clr_i   (accept),
      .inc_i   (consume),
      .cnt_o   (cnt),
      .last_o  (last)
   );

   // Next state: capture on accept, return to IDLE once the last beat is taken.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (accept) begin
         data_d  = data_i;
         state_d = SEND_S;
      end else if (consume && last) begin
         state_d = IDLE_S;
      end else begin
         state_d = state_q;
      end
   end

   // State and captured digest registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE_S;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // Beats come from the captured copy, so data_i may change freely in SEND.
   assign beats   = data_q;
   assign data_o  = reset_i ? '0 : beats[cnt];
   assign ready_o = ~reset_i & en_i & (state_q == IDLE_S);
   assign v_o     = ~reset_i & en_i & (state_q == SEND_S);

endmodule

// File: tb/tb_sha256_disassembler.sv
module tb_sha256_disassembler;

   logic         clk;
   logic         rst;
   logic         en, v, yumi;
   logic [255:0] din;
   logic         ready, vo;
   logic [31:0]  dout;
   logic         en2, v2, yumi2;
   logic [255:0] din2;
   logic         ready2, vo2;
   logic [255:0] dout2;

   int n_cmp = 0;
   int n_bad = 0;

   sha256_disassembler #(.ring_width_p(32), .id_p(1)) dut (
      .clk_i(clk), .reset_i(rst), .en_i(en), .v_i(v), .data_i(din),
      .ready_o(ready), .v_o(vo), .data_o(dout), .yumi_i(yumi));

   sha256_disassembler #(.ring_width_p(256), .id_p(2)) dut256 (
      .clk_i(clk), .reset_i(rst), .en_i(en2), .v_i(v2), .data_i(din2),
      .ready_o(ready2), .v_o(vo2), .data_o(dout2), .yumi_i(yumi2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a queue of beats still owed to the ring.
   // Empty queue = waiting for a digest; otherwise the front beat is on offer.
   logic [31:0] mq[$];
   always @(negedge clk) begin
      logic er;
      logic ev;
      er = !rst && en && (mq.size() == 0);
      ev = !rst && en && (mq.size() != 0);
      chk("model_ready", 256'(ready), 256'(er));
      chk("model_v", 256'(vo), 256'(ev));
      if (ev) chk("model_data", 256'(dout), 256'(mq[0]));
      if (rst) begin
         chk("model_rst_data", 256'(dout), 256'd0);
         mq.delete();
      end else if (ev && yumi) begin
         void'(mq.pop_front());
      end else if (er && v) begin
         for (int k = 0; k < 8; k++) mq.push_back(din[k*32 +: 32]);
      end
   end

   typedef struct {
      string        tag;
      logic         rst, en, v, yumi;
      logic [255:0] d;
      logic         er, ev, cd;
      logic [31:0]  ed;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(input string tag, input logic r, input logic e, input logic vv,
                               input logic y, input logic [255:0] d, input logic er,
                               input logic ev, input logic cd, input logic [31:0] ed);
      vec_t t;
      t.tag = tag; t.rst = r; t.en = e; t.v = vv; t.yumi = y; t.d = d;
      t.er = er; t.ev = ev; t.cd = cd; t.ed = ed;
      vecs.push_back(t);
   endfunction

   initial begin
      logic [255:0] dd, nd, ff, rr;
      int waited;

      rst = 1'b1; en = 1'b1; v = 1'b0; yumi = 1'b0; din = '0;
      en2 = 1'b1; v2 = 1'b0; yumi2 = 1'b0; din2 = '0;

      for (int k = 0; k < 8; k++) dd[k*32 +: 32] = 32'(k + 1);
      nd = ~dd;
      ff = {256{1'b1}};

      // reset state
      add("rst", 1'b1, 1'b1, 1'b1, 1'b1, dd, 1'b0, 1'b0, 1'b1, 32'd0);
      add("rst", 1'b1, 1'b1, 1'b1, 1'b1, dd, 1'b0, 1'b0, 1'b1, 32'd0);
      // single digest, yumi held high
      add("acc30", 1'b0, 1'b1, 1'b1, 1'b0, dd, 1'b1, 1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 8; k++) add("beat30", 1'b0, 1'b1, 1'b0, 1'b1, dd, 1'b0, 1'b1, 1'b1, 32'(k + 1));
      add("idle30", 1'b0, 1'b1, 1'b0, 1'b0, dd, 1'b1, 1'b0, 1'b0, 32'd0);
      // yumi toggling 1/0: 15 cycles
      add("acc31", 1'b0, 1'b1, 1'b1, 1'b0, dd, 1'b1, 1'b0, 1'b0, 32'd0);
      for (int j = 0; j < 15; j++)
         add("beat31", 1'b0, 1'b1, 1'b0, (j % 2 == 0), dd, 1'b0, 1'b1, 1'b1,
             (j == 0) ? 32'd1 : 32'((j + 1) / 2 + 1));
      add("idle31", 1'b0, 1'b1, 1'b0, 1'b0, dd, 1'b1, 1'b0, 1'b0, 32'd0);
      // en_i dropped for 3 cycles after beat 3
      add("acc32", 1'b0, 1'b1, 1'b1, 1'b0, dd, 1'b1, 1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 3; k++) add("beat32", 1'b0, 1'b1, 1'b0, 1'b1, dd, 1'b0, 1'b1, 1'b1, 32'(k + 1));
      for (int k = 0; k < 3; k++) add("en_low32", 1'b0, 1'b0, 1'b1, 1'b1, nd, 1'b0, 1'b0, 1'b0, 32'd0);
      add("resume32", 1'b0, 1'b1, 1'b0, 1'b0, dd, 1'b0, 1'b1, 1'b1, 32'd4);
      for (int k = 3; k < 8; k++) add("beat32", 1'b0, 1'b1, 1'b0, 1'b1, dd, 1'b0, 1'b1, 1'b1, 32'(k + 1));
      add("idle32", 1'b0, 1'b1, 1'b0, 1'b0, dd, 1'b1, 1'b0, 1'b0, 32'd0);
      // reset after beat 5
      add("acc33", 1'b0, 1'b1, 1'b1, 1'b0, dd, 1'b1, 1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 5; k++) add("beat33", 1'b0, 1'b1, 1'b0, 1'b1, dd, 1'b0, 1'b1, 1'b1, 32'(k + 1));
      add("rst33", 1'b1, 1'b1, 1'b1, 1'b1, ff, 1'b0, 1'b0, 1'b1, 32'd0);
      add("acc33f", 1'b0, 1'b1, 1'b1, 1'b0, ff, 1'b1, 1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 8; k++) add("beat33f", 1'b0, 1'b1, 1'b0, 1'b1, dd, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      add("idle33", 1'b0, 1'b1, 1'b0, 1'b0, dd, 1'b1, 1'b0, 1'b0, 32'd0);
      // back-to-back with v_i held high, data_i changed mid-SEND
      add("acc34", 1'b0, 1'b1, 1'b1, 1'b0, dd, 1'b1, 1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 8; k++)
         add("beat34", 1'b0, 1'b1, 1'b1, 1'b1, (k < 3) ? dd : nd, 1'b0, 1'b1, 1'b1, 32'(k + 1));
      add("acc34b", 1'b0, 1'b1, 1'b1, 1'b0, nd, 1'b1, 1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 8; k++)
         add("beat34b", 1'b0, 1'b1, 1'b0, 1'b1, dd, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF ^ 32'(k + 1));
      add("idle34", 1'b0, 1'b1, 1'b0, 1'b0, dd, 1'b1, 1'b0, 1'b0, 32'd0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; en = vecs[i].en; v = vecs[i].v; yumi = vecs[i].yumi; din = vecs[i].d;
         @(negedge clk);
         chk({vecs[i].tag, "_ready"}, 256'(ready), 256'(vecs[i].er));
         chk({vecs[i].tag, "_v"}, 256'(vo), 256'(vecs[i].ev));
         if (vecs[i].cd) chk({vecs[i].tag, "_data"}, 256'(dout), 256'(vecs[i].ed));
         @(posedge clk); #1;
      end
      rst = 1'b0; en = 1'b1; v = 1'b0; yumi = 1'b0;

      // single-beat ring: one yumi completes the digest
      for (int k = 0; k < 8; k++) rr[k*32 +: 32] = $urandom();
      v2 = 1'b1; din2 = rr;
      @(negedge clk);
      chk("w256_ready_idle", 256'(ready2), 256'd1);
      @(posedge clk); #1;
      v2 = 1'b0; din2 = ~rr; yumi2 = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!vo2 && waited < 4) begin
         @(negedge clk);
         waited++;
      end
      chk("w256_v", 256'(vo2), 256'd1);
      chk("w256_latency", 256'(waited), 256'd0);
      chk("w256_data", dout2, rr);
      chk("w256_ready_busy", 256'(ready2), 256'd0);
      @(posedge clk); #1;
      yumi2 = 1'b0;
      @(negedge clk);
      chk("w256_ready_back", 256'(ready2), 256'd1);
      chk("w256_v_done", 256'(vo2), 256'd0);
      @(posedge clk); #1;

      // randomized traffic, checked by the queue model
      for (int c = 0; c < 600; c++) begin
         rst  = ($urandom_range(0, 63) == 0);
         en   = ($urandom_range(0, 7) != 0);
         v    = ($urandom_range(0, 3) == 0);
         yumi = 1'($urandom_range(0, 1));
         for (int k = 0; k < 8; k++) din[k*32 +: 32] = $urandom();
         @(posedge clk); #1;
      end
      rst = 1'b0; en = 1'b1; v = 1'b0; yumi = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
